// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter: grants I- or D-cache line bursts, issues one word per cycle,
// and steers returned read data back to the owner. Define MEM_ARB_RR_EN for round-robin ties.
//
// state | meaning
// IDLE  | no owner, sampling requests
// ISSUE | one word issued per cycle for LINE_WORDS cycles
// DRAIN | all reads issued, waiting for the last word to return
// DONE  | one-cycle done pulse to the owner
module mem_arbiter #(
  parameter int LINE_WORDS = 4,
  parameter int MEM_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_grant,
  output logic        i_rvalid,
  output logic [2:0]  i_rword,
  output logic [15:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_grant,
  output logic [2:0]  d_wword,
  output logic        d_rvalid,
  output logic [2:0]  d_rword,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam int          OFF_BITS  = $clog2(LINE_WORDS) + 1;
  localparam logic [15:0] BASE_MASK = ~16'((1 << OFF_BITS) - 1);
  localparam logic [2:0]  LAST_IDX  = 3'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} stateT;

  stateT       stateQ, stateNext;
  logic        ownerD;
  logic        wrOp;
  logic [15:0] baseAddr;
  logic [2:0]  issueLeft;
  logic [2:0]  issueIdx;
  logic        issuing;
  logic        anyReq;
  logic        pickD;
  logic        granted;

  logic [MEM_LAT-1:0] pipeValid;
  logic [2:0]         pipeIdx [MEM_LAT];
  logic               retValid;
  logic [2:0]         retIdx;
  logic               lastReturn;

  assign anyReq = i_req || d_req;

`ifdef MEM_ARB_RR_EN
  // Remembers the previous winner; starts at I so D takes the first tie.
  logic lastD;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lastD <= 1'b0;
    end else if (stateQ == IDLE && anyReq) begin
      lastD <= pickD;
    end
  end

  assign pickD = d_req && (!i_req || !lastD);
`else
  assign pickD = d_req;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateNext;
    end
  end

  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      IDLE:    if (anyReq) stateNext = ISSUE;
      ISSUE:   if (issueLeft == 3'd0) stateNext = wrOp ? DONE : DRAIN;
      DRAIN:   if (lastReturn) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Burst context is captured once so a dropped request cannot disturb the burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ownerD    <= 1'b0;
      wrOp      <= 1'b0;
      baseAddr  <= 16'h0000;
      issueLeft <= 3'd0;
    end else if (stateQ == IDLE && anyReq) begin
      ownerD    <= pickD;
      wrOp      <= pickD && d_wr;
      baseAddr  <= (pickD ? d_addr : i_addr) & BASE_MASK;
      issueLeft <= LAST_IDX;
    end else if (issuing && issueLeft != 3'd0) begin
      issueLeft <= issueLeft - 3'd1;
    end
  end

  assign issuing  = (stateQ == ISSUE);
  assign issueIdx = LAST_IDX - issueLeft;
  assign granted  = (stateQ != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipeValid <= '0;
      for (int i = 0; i < MEM_LAT; i++) pipeIdx[i] <= 3'd0;
    end else begin
      pipeValid[0] <= issuing && !wrOp;
      pipeIdx[0]   <= issueIdx;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipeValid[i] <= pipeValid[i-1];
        pipeIdx[i]   <= pipeIdx[i-1];
      end
    end
  end

  assign retValid   = pipeValid[MEM_LAT-1];
  assign retIdx     = pipeIdx[MEM_LAT-1];
  assign lastReturn = retValid && (retIdx == LAST_IDX);

  assign i_grant  = granted && !ownerD;
  assign d_grant  = granted && ownerD;
  assign i_done   = (stateQ == DONE) && !ownerD;
  assign d_done   = (stateQ == DONE) && ownerD;

  assign i_rvalid = retValid && !ownerD;
  assign d_rvalid = retValid && ownerD;
  assign i_rword  = i_rvalid ? retIdx : 3'd0;
  assign d_rword  = d_rvalid ? retIdx : 3'd0;
  assign i_rdata  = i_rvalid ? mem_rdata : 16'h0000;
  assign d_rdata  = d_rvalid ? mem_rdata : 16'h0000;

  assign mem_rd    = issuing && !wrOp;
  assign mem_wr    = issuing && wrOp;
  assign mem_addr  = issuing ? (baseAddr + {12'd0, issueIdx, 1'b0}) : 16'h0000;
  assign d_wword   = mem_wr ? issueIdx : 3'd0;
  assign mem_wdata = mem_wr ? d_wdata : 16'h0000;

endmodule
